data_sramlike_bridge: RTL and testbench

Data-side bridge between the MEM stage's SRAM-style memory port and the cache/AXI sram-like bus. It converts each single-cycle pipeline access into an sram-like request with `addr_ok`/`data_ok` handshakes. It raises `data_stall` toward the hazard unit until the access completes, and holds returned read data while other pipeline stalls are still active. It also drains, rather than abandons, a transaction that is in flight when the M stage is flushed by an exception.

---
 rtl/data_sramlike_bridge.sv | 130 +++++++++++++
 tb/tb_data_sramlike_bridge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sramlike_bridge.sv
// data_sramlike_bridge: converts single-cycle MEM-stage SRAM accesses into
// sram-like requests (addr_ok/data_ok). It stalls the pipeline until the
// access completes, holds load data while other stalls persist, and drains
// an in-flight transaction that was flushed by an exception.
module data_sramlike_bridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic        ext_stall,
    input  logic        flush,
    output logic        data_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t      state_reg, state_next;
    logic        discard_reg, discard_next;
    logic [31:0] rdata_buf_reg;
    logic        req_wr_reg;
    logic [1:0]  req_size_reg;
    logic [31:0] req_addr_reg;
    logic [31:0] req_wdata_reg;
    logic        issue;
    logic        done;

    // Issue happens only from IDLE with a live, unflushed access; done marks the data_ok cycle.
    always_comb begin
        issue = (state_reg == IDLE) && data_sram_en && !flush;
        done  = (state_reg == DATA) && data_data_ok;
    end

    // Next-state, discard tracking and bus/stall outputs. data_stall never looks at ext_stall.
    always_comb begin
        state_next   = state_reg;
        discard_next = discard_reg;
        data_req     = 1'b0;
        data_stall   = 1'b0;
        data_wr      = req_wr_reg;
        data_size    = req_size_reg;
        data_addr    = req_addr_reg;
        data_wdata   = req_wdata_reg;
        case (state_reg)
            IDLE: begin
                if (issue) begin
                    data_req   = 1'b1;
                    data_stall = 1'b1;
                    data_wr    = |data_sram_wen;
                    data_size  = data_sram_size;
                    data_addr  = data_sram_addr;
                    data_wdata = data_sram_wdata;
                    state_next = data_addr_ok ? DATA : ADDR;
                end
            end
            ADDR: begin
                // Request stays up until accepted, even if flushed meanwhile.
                data_req   = 1'b1;
                data_stall = 1'b1;
                if (flush) begin
                    discard_next = 1'b1;
                end
                if (data_addr_ok) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                data_stall = !data_data_ok;
                if (data_data_ok) begin
                    // A flushed access (earlier or this cycle) must not park in HOLD.
                    state_next   = (ext_stall && !discard_reg && !flush) ? HOLD : IDLE;
                    discard_next = 1'b0;
                end else if (flush) begin
                    discard_next = 1'b1;
                end
            end
            HOLD: begin
                if (!ext_stall) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (discard_reg && !done) begin
            data_stall = 1'b1;
        end
    end

    // State, discard flag, latched request fields and read buffer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            discard_reg   <= 1'b0;
            rdata_buf_reg <= 32'd0;
            req_wr_reg    <= 1'b0;
            req_size_reg  <= 2'd0;
            req_addr_reg  <= 32'd0;
            req_wdata_reg <= 32'd0;
        end else begin
            state_reg   <= state_next;
            discard_reg <= discard_next;
            if (issue) begin
                req_wr_reg    <= |data_sram_wen;
                req_size_reg  <= data_sram_size;
                req_addr_reg  <= data_sram_addr;
                req_wdata_reg <= data_sram_wdata;
            end
            if (done) begin
                rdata_buf_reg <= data_rdata;
            end
        end
    end

    // Load data bypasses the buffer on the completion cycle so the pipeline can proceed at once.
    assign data_sram_rdata = done ? data_rdata : rdata_buf_reg;

endmodule

// File: tb/tb_data_sramlike_bridge.sv
// Testbench for data_sramlike_bridge: directed per-cycle stimulus pushes the
// hand-computed expected outputs into a queue; a negedge monitor pops and
// compares them against the DUT.
module tb_data_sramlike_bridge;

    logic        clk;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [1:0]  data_sram_size;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        ext_stall;
    logic        flush;
    logic        data_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        req;
        logic        stall;
        logic        chk_f;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    logic        e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;

    data_sramlike_bridge dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_size  (data_sram_size),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .ext_stall       (ext_stall),
        .flush           (flush),
        .data_stall      (data_stall),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s %s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    // Monitor: one expectation per checked cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("txn %-16s req=%0b stall=%0b addr=%h rdata=%h", e.name, data_req, data_stall, data_addr, data_sram_rdata);
            cmp(e.name, "data_req", {31'd0, data_req}, {31'd0, e.req});
            cmp(e.name, "data_stall", {31'd0, data_stall}, {31'd0, e.stall});
            if (e.chk_f) begin
                cmp(e.name, "data_wr", {31'd0, data_wr}, {31'd0, e.wr});
                cmp(e.name, "data_size", {30'd0, data_size}, {30'd0, e.size});
                cmp(e.name, "data_addr", data_addr, e.addr);
                cmp(e.name, "data_wdata", data_wdata, e.wdata);
            end
            if (e.chk_rd) begin
                cmp(e.name, "data_sram_rdata", data_sram_rdata, e.rdata);
            end
        end
    end

    task automatic set_fields(input logic wr, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        e_wr    = wr;
        e_size  = size;
        e_addr  = addr;
        e_wdata = wdata;
    endtask

    task automatic pipe(input logic en, input logic [3:0] wen, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_size  = size;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
    endtask

    task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
        data_addr_ok = aok;
        data_data_ok = dok;
        data_rdata   = rd;
    endtask

    // Push the expectation for the current cycle, then advance to just after the next edge.
    task automatic tick(input string nm, input logic req, input logic stall, input logic chk_rd, input logic [31:0] rd);
        exp_t e;
        e.name   = nm;
        e.req    = req;
        e.stall  = stall;
        e.chk_f  = req;
        e.wr     = e_wr;
        e.size   = e_size;
        e.addr   = e_addr;
        e.wdata  = e_wdata;
        e.chk_rd = chk_rd;
        e.rdata  = rd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn    = 1'b0;
        ext_stall = 1'b0;
        flush     = 1'b0;
        pipe(1'b0, 4'd0, 2'd0, 32'd0, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        set_fields(1'b0, 2'd0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        tick("reset", 1'b0, 1'b0, 1'b1, 32'd0);
        resetn = 1'b1;
        tick("after_reset", 1'b0, 1'b0, 1'b1, 32'd0);

        // Word load, fast bus
        pipe(1'b1, 4'd0, 2'd2, 32'h8000_0010, 32'd0);
        bus(1'b1, 1'b0, 32'd0);
        set_fields(1'b0, 2'd2, 32'h8000_0010, 32'd0);
        tick("ld_fast_c0", 1'b1, 1'b1, 1'b0, 32'd0);
        bus(1'b0, 1'b1, 32'hDEAD_BEEF);
        tick("ld_fast_c1", 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        pipe(1'b0, 4'd0, 2'd0, 32'd0, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        tick("ld_fast_idle", 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);

        // Store with slow accept; inputs scrambled while waiting to prove the request is latched
        pipe(1'b1, 4'b0001, 2'd0, 32'h1000_0003, 32'h0000_0011);
        set_fields(1'b1, 2'd0, 32'h1000_0003, 32'h0000_0011);
        tick("st_slow_c0", 1'b1, 1'b1, 1'b0, 32'd0);
        pipe(1'b1, 4'd0, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_0000);
        tick("st_slow_c1", 1'b1, 1'b1, 1'b0, 32'd0);
        tick("st_slow_c2", 1'b1, 1'b1, 1'b0, 32'd0);
        bus(1'b1, 1'b0, 32'd0);
        tick("st_slow_c3", 1'b1, 1'b1, 1'b0, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        tick("st_slow_wait", 1'b0, 1'b1, 1'b0, 32'd0);
        bus(1'b0, 1'b1, 32'd0);
        tick("st_slow_done", 1'b0, 1'b0, 1'b0, 32'd0);
        pipe(1'b0, 4'd0, 2'd0, 32'd0, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        tick("st_slow_idle", 1'b0, 1'b0, 1'b0, 32'd0);

        // Load finishing under ext_stall
        pipe(1'b1, 4'd0, 2'd2, 32'h8000_0020, 32'd0);
        set_fields(1'b0, 2'd2, 32'h8000_0020, 32'd0);
        bus(1'b1, 1'b0, 32'd0);
        tick("ld_hold_c0", 1'b1, 1'b1, 1'b0, 32'd0);
        ext_stall = 1'b1;
        bus(1'b0, 1'b1, 32'h1234_5678);
        tick("ld_hold_dok", 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        bus(1'b0, 1'b0, 32'hAAAA_AAAA);
        for (int i = 0; i < 3; i++) begin
            tick("ld_hold_wait", 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        end
        ext_stall = 1'b0;
        tick("ld_hold_exit", 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        pipe(1'b0, 4'd0, 2'd0, 32'd0, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        tick("ld_hold_idle", 1'b0, 1'b0, 1'b1, 32'h1234_5678);

        // Flush while waiting for addr_ok: drains, skips HOLD, then a fresh access issues
        pipe(1'b1, 4'd0, 2'd2, 32'h8000_0030, 32'd0);
        set_fields(1'b0, 2'd2, 32'h8000_0030, 32'd0);
        tick("fl_addr_c0", 1'b1, 1'b1, 1'b0, 32'd0);
        flush = 1'b1;
        tick("fl_addr_flush", 1'b1, 1'b1, 1'b0, 32'd0);
        flush = 1'b0;
        pipe(1'b0, 4'd0, 2'd0, 32'd0, 32'd0);
        tick("fl_addr_c2", 1'b1, 1'b1, 1'b0, 32'd0);
        bus(1'b1, 1'b0, 32'd0);
        tick("fl_addr_aok", 1'b1, 1'b1, 1'b0, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        tick("fl_data_wait", 1'b0, 1'b1, 1'b0, 32'd0);
        ext_stall = 1'b1;
        bus(1'b0, 1'b1, 32'h5555_0000);
        tick("fl_data_dok", 1'b0, 1'b0, 1'b1, 32'h5555_0000);
        pipe(1'b1, 4'd0, 2'd2, 32'h8000_0040, 32'd0);
        set_fields(1'b0, 2'd2, 32'h8000_0040, 32'd0);
        bus(1'b1, 1'b0, 32'd0);
        tick("fl_new_issue", 1'b1, 1'b1, 1'b0, 32'd0);
        ext_stall = 1'b0;
        bus(1'b0, 1'b1, 32'h0000_0042);
        tick("fl_new_dok", 1'b0, 1'b0, 1'b1, 32'h0000_0042);
        pipe(1'b0, 4'd0, 2'd0, 32'd0, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        tick("fl_new_idle", 1'b0, 1'b0, 1'b1, 32'h0000_0042);

        // Flush in IDLE together with addr_ok: nothing is issued
        pipe(1'b1, 4'd0, 2'd2, 32'h8000_0044, 32'd0);
        flush = 1'b1;
        bus(1'b1, 1'b0, 32'd0);
        tick("fl_idle", 1'b0, 1'b0, 1'b0, 32'd0);
        flush = 1'b0;
        pipe(1'b0, 4'd0, 2'd0, 32'd0, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        tick("fl_idle_after", 1'b0, 1'b0, 1'b1, 32'h0000_0042);

        // Flush on the data_ok cycle with ext_stall high: back to IDLE, not HOLD
        pipe(1'b1, 4'd0, 2'd2, 32'h8000_0048, 32'd0);
        set_fields(1'b0, 2'd2, 32'h8000_0048, 32'd0);
        bus(1'b1, 1'b0, 32'd0);
        tick("fl_dok_c0", 1'b1, 1'b1, 1'b0, 32'd0);
        flush = 1'b1;
        ext_stall = 1'b1;
        bus(1'b0, 1'b1, 32'h0000_0077);
        tick("fl_dok_c1", 1'b0, 1'b0, 1'b1, 32'h0000_0077);
        flush = 1'b0;
        pipe(1'b1, 4'd0, 2'd2, 32'h8000_004C, 32'd0);
        set_fields(1'b0, 2'd2, 32'h8000_004C, 32'd0);
        bus(1'b1, 1'b0, 32'd0);
        tick("fl_dok_reissue", 1'b1, 1'b1, 1'b0, 32'd0);
        ext_stall = 1'b0;
        bus(1'b0, 1'b1, 32'h0000_0042);
        tick("fl_dok_done", 1'b0, 1'b0, 1'b1, 32'h0000_0042);
        pipe(1'b0, 4'd0, 2'd0, 32'd0, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        tick("fl_dok_idle", 1'b0, 1'b0, 1'b1, 32'h0000_0042);

        // Reset while in DATA
        pipe(1'b1, 4'd0, 2'd2, 32'h8000_0050, 32'd0);
        set_fields(1'b0, 2'd2, 32'h8000_0050, 32'd0);
        bus(1'b1, 1'b0, 32'd0);
        tick("rst_data_c0", 1'b1, 1'b1, 1'b0, 32'd0);
        resetn = 1'b0;
        pipe(1'b0, 4'd0, 2'd0, 32'd0, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        tick("rst_data_c1", 1'b0, 1'b1, 1'b1, 32'h0000_0042);
        resetn = 1'b1;
        tick("rst_data_after", 1'b0, 1'b0, 1'b1, 32'd0);
        pipe(1'b1, 4'd0, 2'd2, 32'h8000_0060, 32'd0);
        set_fields(1'b0, 2'd2, 32'h8000_0060, 32'd0);
        bus(1'b1, 1'b0, 32'd0);
        tick("rst_new_issue", 1'b1, 1'b1, 1'b0, 32'd0);
        bus(1'b0, 1'b1, 32'hCAFE_F00D);
        tick("rst_new_dok", 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
        pipe(1'b0, 4'd0, 2'd0, 32'd0, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        tick("rst_new_idle", 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);

        @(negedge clk);
        #1;
        cmp("scoreboard", "pending", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
